// File: rtl/wave_osc_bank.sv
// Multi-channel phase-accumulator oscillator bank with hard sync, per-channel
// waveform/mute control, an averaging mixer and a 1-bit PWM rendering of the mix.
module wave_osc_bank #(
    parameter int ACC_W  = 16,
    parameter int OUT_W  = 8,
    parameter int NUM_CH = 2,
    parameter int DIV    = 4,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic             cfg_sel,
    input  logic [ACC_W-1:0] cfg_data,
    output logic [OUT_W-1:0] mix_out,
    output logic             pwm_out,
    output logic             tick_o
);
    localparam int LOG_CH = $clog2(NUM_CH);
    localparam int SUM_W  = OUT_W + LOG_CH;
    localparam int PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] pre_r;
    logic [OUT_W-1:0] pwm_cnt_r;
    logic [OUT_W-1:0] mix_r;
    logic [OUT_W-1:0] mix_s;
    logic             pwm_r;
    logic             tick_s;
    logic [ACC_W:0]   add0_s;
    logic [SUM_W-1:0] sum_s;
    logic [ACC_W-1:0] phase_r     [NUM_CH];
    logic [ACC_W-1:0] freq_r      [NUM_CH];
    logic [3:0]       mode_r      [NUM_CH];
    logic [ACC_W-1:0] phase_nxt_s [NUM_CH];

    // Waveform shaping: saw-up, saw-down, triangle (folded on the MSB), square.
    function automatic logic [OUT_W-1:0] wave_sample(input logic [ACC_W-1:0] ph,
                                                     input logic [1:0]       wave);
        logic [OUT_W-1:0] p;
        logic [OUT_W-1:0] q;
        p = ph[ACC_W-1 -: OUT_W];
        q = ph[ACC_W-2 -: OUT_W];
        case (wave)
            2'd0:    wave_sample = p;
            2'd1:    wave_sample = ~p;
            2'd2:    wave_sample = ph[ACC_W-1] ? ~q : q;
            2'd3:    wave_sample = ph[ACC_W-1] ? '0 : '1;
            default: wave_sample = p;
        endcase
    endfunction

    assign tick_s  = ena & rst_n & (pre_r == PRE_LAST);
    assign tick_o  = tick_s;
    assign mix_out = mix_r;
    assign pwm_out = pwm_r;

    // Next phase per channel; channel 0 carry-out forces synced channels to zero.
    always_comb begin
        add0_s = {1'b0, phase_r[0]} + {1'b0, freq_r[0]};
        for (int k = 0; k < NUM_CH; k++) begin
            if ((k > 0) && mode_r[k][2] && add0_s[ACC_W]) begin
                phase_nxt_s[k] = '0;
            end else begin
                phase_nxt_s[k] = phase_r[k] + freq_r[k];
            end
        end
    end

    // Sum of unmuted channel samples, scaled back to OUT_W by the channel count.
    always_comb begin
        sum_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!mode_r[k][3]) begin
                sum_s = sum_s + SUM_W'(wave_sample(phase_r[k], mode_r[k][1:0]));
            end else begin
                sum_s = sum_s;
            end
        end
        mix_s = OUT_W'(sum_s >> LOG_CH);
    end

    // Prescaler, PWM counter and registered mix/PWM outputs, all gated by ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_r     <= '0;
            pwm_cnt_r <= '0;
            mix_r     <= '0;
            pwm_r     <= 1'b0;
        end else if (ena) begin
            pre_r     <= tick_s ? '0 : pre_r + PRE_W'(1);
            pwm_cnt_r <= pwm_cnt_r + OUT_W'(1);
            mix_r     <= mix_s;
            pwm_r     <= (pwm_cnt_r < mix_r);
        end
    end

    // Channel state: phases move on ticks; config writes land after the tick uses old values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                phase_r[k] <= '0;
                freq_r[k]  <= '0;
                mode_r[k]  <= 4'h0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (tick_s) begin
                    phase_r[k] <= phase_nxt_s[k];
                end
                if (cfg_we && (int'(cfg_ch) == k)) begin
                    if (cfg_sel) begin
                        mode_r[k] <= cfg_data[3:0];
                    end else begin
                        freq_r[k] <= cfg_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wave_osc_bank.sv
// Bench for wave_osc_bank: integer-arithmetic reference model checked every cycle,
// plus directed scenarios with hand-computed mix/PWM/tick expectations.
module tb_wave_osc_bank;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic        cfg_we = 1'b0;
    logic        cfg_ch = 1'b0;
    logic        cfg_sel = 1'b0;
    logic [15:0] cfg_data = 16'h0000;
    logic [7:0]  mix_out;
    logic        pwm_out;
    logic        tick_o;

    logic        one_we = 1'b0;
    logic        one_ch = 1'b0;
    logic        one_sel = 1'b0;
    logic [15:0] one_data = 16'h0000;
    logic [7:0]  one_mix;
    logic        one_pwm;
    logic        one_tick;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    int m_phase [2];
    int m_freq  [2];
    int m_mode  [2];
    int m_pre, m_pcnt, m_mix, m_pwm;
    bit m_tk, m_carry;

    always #5 clk = ~clk;

    wave_osc_bank #(.ACC_W(16), .OUT_W(8), .NUM_CH(2), .DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_sel(cfg_sel), .cfg_data(cfg_data), .mix_out(mix_out),
        .pwm_out(pwm_out), .tick_o(tick_o)
    );

    wave_osc_bank #(.ACC_W(16), .OUT_W(8), .NUM_CH(1), .DIV(DIV)) dut_one (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_we(one_we), .cfg_ch(one_ch),
        .cfg_sel(one_sel), .cfg_data(one_data), .mix_out(one_mix),
        .pwm_out(one_pwm), .tick_o(one_tick)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Sample value of one channel from its phase, expressed arithmetically.
    function automatic int chan_sample(input int ph, input int md);
        int q;
        if ((md & 8) != 0) return 0;
        case (md & 3)
            0: return ph / 256;
            1: return 255 - ph / 256;
            2: begin
                q = (ph / 128) % 256;
                return (ph < 32768) ? q : 255 - q;
            end
            default: return (ph < 32768) ? 255 : 0;
        endcase
    endfunction

    // Reference model: advances on every rising edge, clears on reset.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_phase[k] = 0; m_freq[k] = 0; m_mode[k] = 0;
            end
            m_pre = 0; m_pcnt = 0; m_mix = 0; m_pwm = 0;
        end else begin
            if (ena) begin
                m_tk   = (m_pre == DIV - 1);
                m_pwm  = (m_pcnt < m_mix) ? 1 : 0;
                m_pcnt = (m_pcnt + 1) % 256;
                m_mix  = (chan_sample(m_phase[0], m_mode[0]) + chan_sample(m_phase[1], m_mode[1])) / 2;
                m_pre  = m_tk ? 0 : m_pre + 1;
                if (m_tk) begin
                    m_carry    = (m_phase[0] + m_freq[0]) >= 65536;
                    m_phase[0] = (m_phase[0] + m_freq[0]) % 65536;
                    m_phase[1] = (m_carry && ((m_mode[1] & 4) != 0)) ? 0 : (m_phase[1] + m_freq[1]) % 65536;
                end
            end
            if (cfg_we) begin
                if (cfg_sel) m_mode[cfg_ch] = int'(cfg_data[3:0]);
                else         m_freq[cfg_ch] = int'(cfg_data);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        chk("model_mix", int'(mix_out), m_mix);
        chk("model_pwm", int'(pwm_out), m_pwm);
        chk("model_tick", int'(tick_o), (rst_n && ena && m_pre == DIV - 1) ? 1 : 0);
    end

    task automatic wr(input int ch, input int sel, input int data);
        @(posedge clk); #2;
        cfg_we = 1'b1; cfg_ch = ch[0]; cfg_sel = sel[0]; cfg_data = data[15:0];
        @(posedge clk); #2;
        cfg_we = 1'b0;
    endtask

    task automatic go();
        @(posedge clk); #2;
        ena = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0; ena = 1'b0;
        #1;
        chk("rst_mix", int'(mix_out), 0);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_tick", int'(tick_o), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick_o !== 1'b1 && n < 20);
        if (tick_o !== 1'b1) chk("tick_timeout", 0, 1);
    endtask

    // Mix reflecting the phase produced by the next tick, two cycles on.
    task automatic after_tick(input string name, input int exp);
        int n;
        wait_tick(n);
        @(negedge clk);
        @(negedge clk);
        chk(name, int'(mix_out), exp);
    endtask

    initial begin
        int n, cnt;
        int tri_exp [4];
        int syn_exp [4];
        tri_exp = '{8'h40, 8'h7F, 8'h3F, 8'h00};
        syn_exp = '{8'h08, 8'h10, 8'h18, 8'h00};

        // Reset with ena high and config traffic: outputs stay at zero.
        ena = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            cfg_we = 1'b1; cfg_ch = i[0]; cfg_sel = i[1]; cfg_data = 16'h1234 + 16'(i);
            #1;
            chk("rst_act_mix", int'(mix_out), 0);
            chk("rst_act_pwm", int'(pwm_out), 0);
            chk("rst_act_tick", int'(tick_o), 0);
        end
        @(posedge clk); #2;
        cfg_we = 1'b0;
        rst_n = 1'b1;
        wait_tick(n);
        chk("first_tick_gap", n, 4);
        wait_tick(n);
        chk("tick_period", n, 4);
        wait_tick(n);
        chk("tick_period2", n, 4);

        // Saw-up ramp over a full wrap, channel 1 muted.
        do_reset();
        wr(1, 1, 8);
        wr(0, 0, 16'h0100);
        go();
        for (int k = 1; k <= 257; k++) after_tick("saw_ramp", (k % 256) / 2);

        // Half-rate saw-up alternates 0x80 / 0x00.
        do_reset();
        wr(1, 1, 8);
        wr(0, 0, 16'h8000);
        go();
        for (int k = 1; k <= 4; k++) after_tick("saw_half", (k % 2 == 1) ? 8'h40 : 8'h00);

        // Triangle at quarter rate: 0x80, 0xFF, 0x7F, 0x00.
        do_reset();
        wr(1, 1, 8);
        wr(0, 1, 2);
        wr(0, 0, 16'h4000);
        go();
        for (int k = 0; k < 8; k++) after_tick("triangle", tri_exp[k % 4]);

        // Hard sync: ch1 restarts on every ch0 wrap.
        do_reset();
        wr(0, 1, 8);
        wr(0, 0, 16'h4000);
        wr(1, 1, 4);
        wr(1, 0, 16'h1000);
        go();
        for (int k = 0; k < 12; k++) after_tick("hard_sync", syn_exp[k % 4]);

        // PWM duty at full-scale mix.
        do_reset();
        wr(0, 1, 3);
        wr(1, 1, 3);
        go();
        repeat (3) @(negedge clk);
        chk("square_mix", int'(mix_out), 8'hFF);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (pwm_out) cnt++;
        end
        chk("pwm_high_ff", cnt, 255);

        // PWM duty at mix 0x40, frozen by clearing FREQ after one tick.
        do_reset();
        wr(1, 1, 8);
        wr(0, 0, 16'h8000);
        go();
        wait_tick(n);
        @(posedge clk); #2;
        ena = 1'b0;
        wr(0, 0, 0);
        go();
        repeat (3) @(negedge clk);
        chk("quarter_mix", int'(mix_out), 8'h40);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (pwm_out) cnt++;
        end
        chk("pwm_high_40", cnt, 64);

        // FREQ write in the tick cycle: old FREQ for this tick, new from the next.
        do_reset();
        wr(0, 1, 8);
        wr(1, 0, 16'h1000);
        go();
        wait_tick(n);
        cfg_we = 1'b1; cfg_ch = 1'b1; cfg_sel = 1'b0; cfg_data = 16'h3000;
        @(posedge clk); #2;
        cfg_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("same_cycle_old", int'(mix_out), 8'h08);
        after_tick("same_cycle_new", 8'h20);
        after_tick("same_cycle_new2", 8'h38);

        // Single-channel instance: out-of-range channel write changes nothing.
        do_reset();
        @(posedge clk); #2;
        one_we = 1'b1; one_ch = 1'b1; one_sel = 1'b0; one_data = 16'h8000;
        @(posedge clk); #2;
        one_we = 1'b0;
        ena = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_tick(n);
            @(negedge clk);
            @(negedge clk);
            chk("oor_write", int'(one_mix), 0);
        end
        @(posedge clk); #2;
        one_we = 1'b1; one_ch = 1'b0; one_sel = 1'b0; one_data = 16'h8000;
        @(posedge clk); #2;
        one_we = 1'b0;
        wait_tick(n);
        @(negedge clk);
        @(negedge clk);
        chk("inrange_write", int'(one_mix), 8'h80);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
